// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a per-register busy
// scoreboard for tracking in-flight long-latency producers.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - same-cycle write-to-read forwarding; a forward hit forces read_ready
//   undefined - reads always return the stored array value
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (clears registers and busy bits)
//   write_en     per write port enable            [NUM_WRITE]
//   write_addr   per write port address           [NUM_WRITE*ADDR_WIDTH]
//   write_data   per write port data              [NUM_WRITE*DATA_WIDTH]
//   read_en      per read port enable             [NUM_READ]
//   read_addr    per read port address            [NUM_READ*ADDR_WIDTH]
//   read_data    per read port data, combinational [NUM_READ*DATA_WIDTH]
//   read_ready   per read port operand-final flag  [NUM_READ]
//   mark_en      set busy bit of mark_addr at the edge
//   mark_addr    register to mark busy
//   busy_vec     registered busy bits             [2**ADDR_WIDTH]
//
// Higher write port index = younger instruction, so it wins on collisions.
module regfile_mp #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned NUM_READ   = 4,
   parameter int unsigned NUM_WRITE  = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_WRITE-1:0]             write_en,
   input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  write_addr,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0]  write_data,
   input  logic [NUM_READ-1:0]              read_en,
   input  logic [NUM_READ*ADDR_WIDTH-1:0]   read_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0]   read_data,
   output logic [NUM_READ-1:0]              read_ready,
   input  logic                             mark_en,
   input  logic [ADDR_WIDTH-1:0]            mark_addr,
   output logic [(2**ADDR_WIDTH)-1:0]       busy_vec
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [Depth];
   logic [DATA_WIDTH-1:0] regs_d [Depth];
   logic [Depth-1:0]      busy_q;
   logic [Depth-1:0]      busy_d;

   logic [ADDR_WIDTH-1:0] waddr [NUM_WRITE];
   logic [DATA_WIDTH-1:0] wdata [NUM_WRITE];
   logic [ADDR_WIDTH-1:0] raddr [NUM_READ];
   logic [DATA_WIDTH-1:0] rdata [NUM_READ];
   logic [NUM_READ-1:0]   rready;

   // Unpack the flat port buses into per-port views.
   for (genvar g = 0; g < NUM_WRITE; g++) begin : g_wunpack
      assign waddr[g] = write_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata[g] = write_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   for (genvar g = 0; g < NUM_READ; g++) begin : g_rpack
      assign raddr[g]                           = read_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign read_data[g*DATA_WIDTH +: DATA_WIDTH] = rdata[g];
   end

   assign read_ready = rready;
   assign busy_vec   = busy_q;

   // Next-state: ascending port order so the youngest (highest index) write lands last.
   always_comb begin
      for (int a = 0; a < Depth; a++) begin
         regs_d[a] = regs_q[a];
      end
      busy_d = busy_q;
      for (int k = 0; k < NUM_WRITE; k++) begin
         if (write_en[k]) begin
            busy_d[waddr[k]] = 1'b0;
            if (waddr[k] != '0) begin
               regs_d[waddr[k]] = wdata[k];
            end
         end
      end
      // A new producer supersedes any write completing this cycle.
      if (mark_en && (mark_addr != '0)) begin
         busy_d[mark_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int a = 0; a < Depth; a++) begin
            regs_q[a] <= '0;
         end
         busy_q <= '0;
      end else begin
         for (int a = 0; a < Depth; a++) begin
            regs_q[a] <= regs_d[a];
         end
         busy_q <= busy_d;
      end
   end

   // Combinational read ports.
   always_comb begin
      for (int i = 0; i < NUM_READ; i++) begin
         rdata[i]  = '0;
         rready[i] = 1'b0;
         if (!rst) begin
            if (!read_en[i] || (raddr[i] == '0)) begin
               rready[i] = 1'b1;
            end else begin
               rdata[i]  = regs_q[raddr[i]];
               rready[i] = ~busy_q[raddr[i]];
`ifdef REGFILE_BYPASS_EN
               // Ascending scan: the youngest matching writer is forwarded.
               for (int k = 0; k < NUM_WRITE; k++) begin
                  if (write_en[k] && (waddr[k] == raddr[i])) begin
                     rdata[i]  = wdata[k];
                     rready[i] = 1'b1;
                  end
               end
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned NR    = 4;
   localparam int unsigned NW    = 2;
   localparam int unsigned DEPTH = 1 << AW;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NW-1:0]       write_en = '0;
   logic [NW*AW-1:0]    write_addr = '0;
   logic [NW*DW-1:0]    write_data = '0;
   logic [NR-1:0]       read_en = '0;
   logic [NR*AW-1:0]    read_addr = '0;
   logic [NR*DW-1:0]    read_data;
   logic [NR-1:0]       read_ready;
   logic                mark_en = 1'b0;
   logic [AW-1:0]       mark_addr = '0;
   logic [DEPTH-1:0]    busy_vec;

   regfile_mp #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .NUM_READ  (NR),
      .NUM_WRITE (NW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .write_en  (write_en),
      .write_addr(write_addr),
      .write_data(write_data),
      .read_en   (read_en),
      .read_addr (read_addr),
      .read_data (read_data),
      .read_ready(read_ready),
      .mark_en   (mark_en),
      .mark_addr (mark_addr),
      .busy_vec  (busy_vec)
   );

   always #5 clk = ~clk;

   // Stimulus for the next cycle.
   logic [NW-1:0] we;
   logic [AW-1:0] wa [NW];
   logic [DW-1:0] wd [NW];
   logic [NR-1:0] re;
   logic [AW-1:0] ra [NR];
   logic          mk;
   logic [AW-1:0] ma;
   logic          rs;

   // Reference model: architectural register contents and outstanding producers.
   logic [DW-1:0] m_mem  [DEPTH];
   bit            m_busy [DEPTH];
   bit            m_known = 1'b0;

   typedef struct {
      string            name;
      logic [NR*DW-1:0] data;
      logic [NR-1:0]    rdy;
      logic [DEPTH-1:0] busy;
      bit               chk_busy;
   } exp_t;

   exp_t exp_q [$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic clear_stim();
      we = '0; re = '0; mk = 1'b0; ma = '0; rs = 1'b0;
      for (int k = 0; k < NW; k++) begin wa[k] = '0; wd[k] = '0; end
      for (int i = 0; i < NR; i++) ra[i] = '0;
   endtask

   task automatic step(input string name);
      exp_t e;
      @(posedge clk);
      #1;
      rst = rs; write_en = we; read_en = re; mark_en = mk; mark_addr = ma;
      for (int k = 0; k < NW; k++) begin
         write_addr[k*AW +: AW] = wa[k];
         write_data[k*DW +: DW] = wd[k];
      end
      for (int i = 0; i < NR; i++) read_addr[i*AW +: AW] = ra[i];

      e.name = name; e.data = '0; e.rdy = '0; e.busy = '0; e.chk_busy = m_known;
      for (int i = 0; i < NR; i++) begin
         logic [DW-1:0] v;
         bit            r;
         v = '0; r = 1'b0;
         if (!rs) begin
            if (!re[i] || ra[i] == 0) begin
               r = 1'b1;
            end else begin
               v = m_mem[ra[i]];
               r = !m_busy[ra[i]];
`ifdef REGFILE_BYPASS_EN
               // Youngest write to this register in flight this cycle.
               for (int k = NW - 1; k >= 0; k--) begin
                  if (we[k] && wa[k] == ra[i]) begin
                     v = wd[k]; r = 1'b1;
                     break;
                  end
               end
`endif
            end
         end
         e.data[i*DW +: DW] = v;
         e.rdy[i]           = r;
      end
      for (int a = 0; a < DEPTH; a++) e.busy[a] = m_busy[a];
      exp_q.push_back(e);

      // Advance the model across the edge.
      if (rs) begin
         for (int a = 0; a < DEPTH; a++) begin m_mem[a] = '0; m_busy[a] = 1'b0; end
         m_known = 1'b1;
      end else begin
         for (int k = 0; k < NW; k++) begin
            if (we[k]) begin
               m_busy[wa[k]] = 1'b0;
               if (wa[k] != 0) m_mem[wa[k]] = wd[k];
            end
         end
         if (mk && ma != 0) m_busy[ma] = 1'b1;
      end
   endtask

   // Monitor: compares what the DUT presents mid-cycle against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (read_data !== e.data) begin
               n_fail++;
               $display("FAIL %s read_data: got %h expected %h", e.name, read_data, e.data);
            end
            n_cmp++;
            if (read_ready !== e.rdy) begin
               n_fail++;
               $display("FAIL %s read_ready: got %b expected %b", e.name, read_ready, e.rdy);
            end
            if (e.chk_busy) begin
               n_cmp++;
               if (busy_vec !== e.busy) begin
                  n_fail++;
                  $display("FAIL %s busy_vec: got %h expected %h", e.name, busy_vec, e.busy);
               end
            end
         end
      end
   end

   initial begin
      int hi;
      for (int a = 0; a < DEPTH; a++) begin m_mem[a] = '0; m_busy[a] = 1'b0; end

      // 1. Reset for two cycles (writes/marks presented are ignored), then read all.
      clear_stim(); rs = 1'b1; we = 2'b11; wa[0] = 5'd1; wd[0] = 32'hBAD; wa[1] = 5'd2;
      mk = 1'b1; ma = 5'd3; re = '1; ra[0] = 5'd1;
      step("reset0");
      step("reset1");
      for (int b = 0; b < DEPTH; b += NR) begin
         clear_stim(); re = '1;
         for (int i = 0; i < NR; i++) ra[i] = AW'(b + i);
         step("idle_read");
      end

      // 2. Dual write then readback.
      clear_stim(); we = 2'b11; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; wa[1] = 5'd6;
      wd[1] = 32'h12345678;
      step("wr_5_6");
      clear_stim(); re = 4'b0011; ra[0] = 5'd5; ra[1] = 5'd6; ra[2] = 5'd5;
      step("rd_5_6");

      // 3. Collision on x7 and write to x0.
      clear_stim(); we = 2'b11; wa[0] = 5'd7; wd[0] = 32'h1111; wa[1] = 5'd7; wd[1] = 32'h2222;
      step("collide_7");
      clear_stim(); we = 2'b01; wa[0] = 5'd0; wd[0] = 32'hFFFF; re = '1; ra[0] = 5'd7;
      step("wr_x0");
      clear_stim(); re = '1; ra[0] = 5'd0; ra[1] = 5'd7; ra[2] = 5'd0; ra[3] = 5'd6;
      step("rd_x0_x7");

      // 4. Same-cycle write and read of x9.
      clear_stim(); we = 2'b10; wa[1] = 5'd9; wd[1] = 32'hA5A5A5A5; re = '1; ra[0] = 5'd9;
      ra[3] = 5'd9;
      step("bypass_9");
      clear_stim(); re = 4'b0001; ra[0] = 5'd9;
      step("after_9");

      // 5. Scoreboard on x10.
      clear_stim(); mk = 1'b1; ma = 5'd10;
      step("mark_10");
      clear_stim(); re = 4'b0001; ra[0] = 5'd10;
      step("busy_10");
      clear_stim(); we = 2'b01; wa[0] = 5'd10; wd[0] = 32'hCAFE; re = 4'b0010; ra[1] = 5'd10;
      step("wr_busy_10");
      clear_stim(); re = 4'b0001; ra[0] = 5'd10;
      step("clear_10");
      clear_stim(); mk = 1'b1; ma = 5'd10; we = 2'b10; wa[1] = 5'd10; wd[1] = 32'hBEEF;
      step("mark_wr_10");
      clear_stim(); re = 4'b0001; ra[0] = 5'd10; mk = 1'b1; ma = 5'd0;
      step("still_busy_10");

      // 6. Reset mid-operation.
      clear_stim(); mk = 1'b1; ma = 5'd3; we = 2'b01; wa[0] = 5'd4; wd[0] = 32'h55;
      step("mark3_wr4");
      clear_stim(); rs = 1'b1; we = 2'b10; wa[1] = 5'd4; wd[1] = 32'h77; mk = 1'b1; ma = 5'd4;
      re = '1; ra[0] = 5'd4;
      step("mid_reset");
      clear_stim(); re = '1; ra[0] = 5'd4; ra[1] = 5'd3; ra[2] = 5'd5;
      step("post_reset");

      // Random traffic: narrow address range first to force collisions and hits.
      for (int c = 0; c < 400; c++) begin
         hi = (c < 250) ? 11 : DEPTH - 1;
         clear_stim();
         rs = ($urandom_range(0, 59) == 0);
         for (int k = 0; k < NW; k++) begin
            we[k] = 1'($urandom_range(0, 1));
            wa[k] = AW'($urandom_range(0, hi));
            wd[k] = $urandom;
         end
         re = NR'($urandom);
         for (int i = 0; i < NR; i++) ra[i] = AW'($urandom_range(0, hi));
         mk = ($urandom_range(0, 2) == 0);
         ma = AW'($urandom_range(0, hi));
         step("random");
      end

      clear_stim();
      step("drain");
      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
